// File: rtl/dbg_pkg.sv
// Shared debug-subsystem definitions: trace FSM states, capture modes,
// the trace control/status CSR address map and a mode decode helper.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_FREE      = 2'd0,
    MODE_STOP_FULL = 2'd1,
    MODE_TRIG_POST = 2'd2
  } trace_mode_e;

  // Debug CSR address map for trace control and status.
  localparam logic [11:0] CSR_TRACE_CTRL   = 12'h7C0;
  localparam logic [11:0] CSR_TRACE_STATUS = 12'h7C1;
  localparam logic [11:0] CSR_TRACE_POST   = 12'h7C2;
  localparam logic [11:0] CSR_TRACE_MASK   = 12'h7C3;
  localparam logic [11:0] CSR_TRACE_DATA   = 12'h7C4;

  // Raw 2-bit mode field to capture mode; the reserved encoding runs free.
  function automatic trace_mode_e f_decode_mode(input logic [1:0] raw);
    trace_mode_e mode;
    case (raw)
      2'd1:    mode = MODE_STOP_FULL;
      2'd2:    mode = MODE_TRIG_POST;
      default: mode = MODE_FREE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/dbg_trace_capture_if.sv
// Capture bus from the retire stage plus the valid/ready readout stream
// towards the debug coprocessor.
interface dbg_trace_capture_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int TS_WIDTH   = 32
);
  logic                  cap_valid;
  logic [ADDR_WIDTH-1:0] cap_pc;
  logic [INST_WIDTH-1:0] cap_inst;
  logic [ADDR_WIDTH-1:0] cap_mem_addr;
  logic [DATA_WIDTH-1:0] cap_mem_data;
  logic                  cap_mem_write;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_pc;
  logic [INST_WIDTH-1:0] rd_inst;
  logic [ADDR_WIDTH-1:0] rd_mem_addr;
  logic [DATA_WIDTH-1:0] rd_mem_data;
  logic                  rd_mem_write;
  logic [TS_WIDTH-1:0]   rd_ts;

  // Environment side: produces captures, consumes the readout stream.
  modport master (
    output cap_valid, cap_pc, cap_inst, cap_mem_addr, cap_mem_data, cap_mem_write,
    output rd_ready,
    input  rd_valid, rd_pc, rd_inst, rd_mem_addr, rd_mem_data, rd_mem_write, rd_ts
  );

  // Trace unit side.
  modport slave (
    input  cap_valid, cap_pc, cap_inst, cap_mem_addr, cap_mem_data, cap_mem_write,
    input  rd_ready,
    output rd_valid, rd_pc, rd_inst, rd_mem_addr, rd_mem_data, rd_mem_write, rd_ts
  );
endinterface

// File: rtl/dbg_trace_ram.sv
// Simple dual-port trace storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module dbg_trace_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store one packed trace entry per write strobe.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/dbg_trace_capture.sv
// Trace capture unit: circular buffer of retired-instruction entries with
// free-running, stop-on-full and trigger/post-count capture modes, and a
// fall-through valid/ready readout of the oldest entry.
module dbg_trace_capture
  import dbg_pkg::*;
#(
  parameter int  ADDR_WIDTH  = 64,
  parameter int  DATA_WIDTH  = 64,
  parameter int  INST_WIDTH  = 32,
  parameter int  DEPTH       = 256,
  parameter int  TS_WIDTH    = 32,
  parameter int  NUM_TRIG_IN = 4,
  localparam int CW          = $clog2(DEPTH) + 1,
  localparam int SW          = $clog2(NUM_TRIG_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cfg_enable,
  input  logic [1:0]             i_cfg_mode,
  input  logic [CW-1:0]          i_cfg_post_count,
  input  logic [NUM_TRIG_IN-1:0] i_cfg_trig_mask,
  input  logic                   i_cfg_clear,
  input  logic [NUM_TRIG_IN-1:0] i_trig_in,
  dbg_trace_capture_if.slave     tr,
  output logic [1:0]             o_st_state,
  output logic [CW-1:0]          o_st_count,
  output logic                   o_st_overflow,
  output logic                   o_st_triggered,
  output logic [SW-1:0]          o_st_trig_src,
  output logic                   o_done_irq
);
  localparam int PW = CW - 1;
  localparam int EW = 2 * ADDR_WIDTH + INST_WIDTH + DATA_WIDTH + 1 + TS_WIDTH;
  localparam logic [CW-1:0] LP_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ALMOST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LP_ONE    = CW'(1);
  localparam logic [PW-1:0] LP_PTR_INC = PW'(1);

  trace_state_e          r_state, w_state_nxt;
  trace_mode_e           r_mode;
  logic [CW-1:0]         r_post, r_remaining, r_count;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [TS_WIDTH-1:0]   r_ts;
  logic                  r_overflow, r_triggered, r_done_irq;
  logic [SW-1:0]         r_trig_src;

  logic                   w_push, w_pop, w_full, w_hit, w_arm, w_clear;
  logic                   w_wr_en, w_overwrite;
  logic [NUM_TRIG_IN-1:0] w_hit_vec;
  logic [EW-1:0]          w_wr_data, w_rd_data;

  // Index of the lowest set bit; used to report the winning trigger input.
  function automatic logic [SW-1:0] f_lowest_set(input logic [NUM_TRIG_IN-1:0] vec);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = NUM_TRIG_IN - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = SW'(i);
      end
    end
    return idx;
  endfunction

  assign w_push    = tr.cap_valid && ((r_state == ST_ARMED) || (r_state == ST_POST));
  assign w_pop     = tr.rd_valid && tr.rd_ready;
  assign w_full    = (r_count == LP_FULL);
  assign w_hit_vec = i_trig_in & i_cfg_trig_mask;
  assign w_hit     = |w_hit_vec;
  assign w_arm     = (r_state == ST_IDLE) && i_cfg_enable;
  assign w_clear   = i_cfg_clear && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Stop-on-full never overwrites; other modes drop the oldest entry when full.
  assign w_wr_en     = w_push && !(w_full && !w_pop && (r_mode == MODE_STOP_FULL));
  assign w_overwrite = w_wr_en && w_full && !w_pop;

  assign w_wr_data = {tr.cap_pc, tr.cap_inst, tr.cap_mem_addr, tr.cap_mem_data,
                      tr.cap_mem_write, r_ts};

  dbg_trace_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign {tr.rd_pc, tr.rd_inst, tr.rd_mem_addr, tr.rd_mem_data,
          tr.rd_mem_write, tr.rd_ts} = w_rd_data;
  assign tr.rd_valid = (r_count != '0);

  // Next-state decode for the capture FSM.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_cfg_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ARMED;
        ST_ARMED: begin
          if ((r_mode == MODE_STOP_FULL) && w_push && !w_pop && (r_count == LP_ALMOST)) begin
            w_state_nxt = ST_DONE;
          end else if ((r_mode == MODE_TRIG_POST) && w_hit) begin
            w_state_nxt = (r_post == '0) ? ST_DONE : ST_POST;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
        ST_POST: begin
          if (w_push && (r_remaining == LP_ONE)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_POST;
          end
        end
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state, sampled configuration, post-trigger countdown and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_FREE;
      r_post      <= '0;
      r_remaining <= '0;
      r_done_irq  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done_irq <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
      if (w_arm) begin
        r_mode <= f_decode_mode(i_cfg_mode);
        r_post <= i_cfg_post_count;
      end
      if ((r_state == ST_ARMED) && (w_state_nxt == ST_POST)) begin
        r_remaining <= r_post;
      end else if ((r_state == ST_POST) && w_push) begin
        r_remaining <= r_remaining - LP_ONE;
      end
    end
  end

  // Buffer pointers, occupancy and overwrite flag; clear beats a same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_arm || w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_INC;
      end
      if (w_pop || w_overwrite) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_INC;
      end
      if (w_wr_en && !w_pop && !w_full) begin
        r_count <= r_count + LP_ONE;
      end else if (w_pop && !w_wr_en) begin
        r_count <= r_count - LP_ONE;
      end
      if (w_overwrite) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Latch the first masked trigger seen while armed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_triggered <= 1'b0;
      r_trig_src  <= '0;
    end else if (w_arm || w_clear) begin
      r_triggered <= 1'b0;
      r_trig_src  <= '0;
    end else if ((r_state == ST_ARMED) && w_hit && !r_triggered) begin
      r_triggered <= 1'b1;
      r_trig_src  <= f_lowest_set(w_hit_vec);
    end
  end

  // Free-running capture timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  assign o_st_state     = r_state;
  assign o_st_count     = r_count;
  assign o_st_overflow  = r_overflow;
  assign o_st_triggered = r_triggered;
  assign o_st_trig_src  = r_trig_src;
  assign o_done_irq     = r_done_irq;
endmodule
